store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Post-retirement store buffer between the ROB retire bus and data memory. Generalised, parametrised successor of the single-entry write-cache (data/address/valid) used today.
- Holds DEPTH committed stores with byte enables. Coalesces same-word stores and drains the oldest store to memory with a valid/ack handshake.
- Forwards buffered data to younger loads, so the ROB can retire stores without waiting for memory.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, >=2.
- ADDR_W, 32, byte address width.
- DATA_W, 32, store data width; multiple of 8.
- BE_W, DATA_W/8, byte-enable width (derived, not overridable).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
- clk in 1: single clock, all state on rising edge.
- rst in 1: synchronous, active-high reset.
- st_valid in 1: retire bus offers a store (store_ready of retired instruction).
- st_addr in ADDR_W: store byte address.
- st_data in DATA_W: store data, already lane-aligned.
- st_be in BE_W: byte enables; nonzero when st_valid.
- st_accept out 1: store taken this cycle; drives store_executed back to retire bus.
- mem_wr_en out 1: head entry offered to memory.
- mem_wr_addr out ADDR_W: head word address, low log2(BE_W) bits zero.
- mem_wr_data out DATA_W: head data.
- mem_wr_be out BE_W: head byte enables.
- mem_wr_ack in 1: memory consumed the head this cycle.
- ld_lookup in 1: load address probe.
- ld_addr in ADDR_W: load byte address.
- ld_be in BE_W: bytes the load needs.
- ld_hit out 1: all requested bytes supplied by the buffer.
- ld_data out DATA_W: forwarded data, merged youngest-first per byte.
- ld_conflict out 1: some but not all requested bytes are buffered; load must replay.
- count out CNT_W: occupancy.
- empty out 1; full out 1.

Behaviour:
- Reset: all entry valid bits cleared; head and tail pointers 0. Outputs: count=0, empty=1, full=0, st_accept=0, mem_wr_en=0, mem_wr_* =0, ld_hit=0, ld_conflict=0, ld_data=0. Reset mid-drain discards all entries with no write issued.
- Circular FIFO; head=oldest. Pointers wrap modulo DEPTH.
- Word match: addr[ADDR_W-1:log2(BE_W)] equal.
- Coalesce: st_valid matches a valid non-head entry -> merge in place, no new entry, count unchanged.
  - Per-byte merge: bytes with st_be=1 overwrite; entry be |= st_be.
  - If several non-head entries match, merge into the youngest.
  - The head is never coalesced, because it may be in flight.
- Push: st_valid with no coalesce hit writes the tail entry, tail+1, count+1.
- st_accept is combinational: st_valid && (coalesce_hit || !full || mem_wr_ack). Full plus ack in the same cycle accepts a push and pop together; count is unchanged.
- Drain: mem_wr_en = !empty. mem_wr_* shows the head and holds stable until ack. On ack: head invalidated, head+1, count-1.
- Push and pop in the same cycle on a non-full buffer: count unchanged.
- Pop on empty cannot occur, since mem_wr_en=0; an ack while empty is ignored.
- Empty buffer plus st_valid: the entry is written and mem_wr_en rises the next cycle (1-cycle store-to-memory latency minimum).
- Forwarding is combinational and covers all valid entries, head included.
  - Per byte, take the youngest matching entry whose be covers that byte.
  - covered = OR of matching be bits. ld_hit = ld_lookup && ((covered & ld_be) == ld_be) && ld_be != 0.
  - ld_conflict = ld_lookup && (covered & ld_be) != 0 && !ld_hit.
  - ld_data bytes not covered = 0.
  - A store being accepted in the same cycle is not visible to the lookup until the next cycle.
- ROB flush has no effect: buffered stores are architecturally committed.
- count, empty and full are registered, derived from the next-state count.

Test Plan:
- Reset then a single store addr=0x100, data=0xDEADBEEF, be=4'hF: st_accept=1 in cycle 0; mem_wr_en=1 in cycle 1 with addr 0x100; ack in cycle 3 -> empty=1 in cycle 4, count 1->0.
- Fill DEPTH=4 with no ack: 5th store sees st_accept=0, full=1. Assert ack while the 5th is still held -> st_accept=1 that cycle, count stays 4, head advances.
- Coalesce: queue A=0x200 (head), B=0x300 be=4'h3 data=0x00001111, then 0x302 be=4'hC data=0x22220000 -> count stays 2. B drains as data=0x22221111 be=4'hF.
- Store to the head address 0x200 while the head is undrained -> new entry allocated, count+1; memory sees two writes to 0x200 in order.
- Forwarding: buffer holds 0x400 be=4'h1 data=0xAB. Load 0x400 be=4'h1 -> ld_hit=1, ld_data=0x000000AB. Load be=4'h3 -> ld_conflict=1, ld_hit=0. Load 0x404 -> both 0.
- Assert rst with 3 entries and mem_wr_en high -> next cycle count=0, empty=1, mem_wr_en=0, and no later write is issued.

Source files
------------

// File: rtl/store_write_buffer.sv
// ---------------------------------------------------------------------------
// store_write_buffer
//   Post-retirement store buffer sitting between the ROB retire bus and data
//   memory. Holds up to DEPTH committed stores (word address, data, byte
//   enables) in a circular FIFO. It coalesces same-word stores into the
//   youngest matching non-head entry, drains the oldest entry to memory over a
//   valid/ack handshake, and forwards buffered bytes to younger loads.
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   st_valid/st_addr/st_data/st_be: retire-bus store offer
//   st_accept                     : store taken this cycle (combinational)
//   mem_wr_en/addr/data/be        : head entry offered to memory
//   mem_wr_ack                    : memory consumed the head this cycle
//   ld_lookup/ld_addr/ld_be       : load forwarding probe
//   ld_hit/ld_data/ld_conflict    : forwarding result (combinational)
//   count/empty/full              : registered occupancy status
// ---------------------------------------------------------------------------

// Per-entry word-address comparator, one instance per buffer slot.
module swb_entry_cmp #(
    parameter int ADDR_W = 32
) (
    input  logic              ent_valid,
    input  logic [ADDR_W-1:0] ent_addr,
    input  logic [ADDR_W-1:0] st_word,
    input  logic [ADDR_W-1:0] ld_word,
    output logic              st_match,
    output logic              ld_match
);
    assign st_match = ent_valid && (ent_addr == st_word);
    assign ld_match = ent_valid && (ent_addr == ld_word);
endmodule

module store_write_buffer #(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [BE_W-1:0]   st_be,
    output logic              st_accept,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [BE_W-1:0]   mem_wr_be,
    input  logic              mem_wr_ack,
    input  logic              ld_lookup,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [BE_W-1:0]   ld_be,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_conflict,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(BE_W);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;   // word address, low OFF_W bits zero
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } entry_t;

    entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               empty_q, empty_d, full_q, full_d;

    logic [ADDR_W-1:0]  st_word, ld_word;
    logic [DEPTH-1:0]   st_match, ld_match;
    logic               coal_hit, push, pop;
    logic [PTR_W-1:0]   coal_idx, c_idx, f_idx;
    logic [BE_W-1:0]    covered;
    logic [DATA_W-1:0]  fwd_data;

    assign st_word = st_addr & ~OFF_MASK;
    assign ld_word = ld_addr & ~OFF_MASK;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        swb_entry_cmp #(.ADDR_W(ADDR_W)) u_cmp (
            .ent_valid (ent_q[i].valid),
            .ent_addr  (ent_q[i].addr),
            .st_word   (st_word),
            .ld_word   (ld_word),
            .st_match  (st_match[i]),
            .ld_match  (ld_match[i])
        );
    end

    // Coalesce target: walk oldest-to-youngest skipping the head (it may be
    // in flight to memory), so the last match seen is the youngest.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = head_q;
        c_idx    = head_q;
        for (int k = 1; k < DEPTH; k++) begin
            c_idx = head_q + PTR_W'(k);
            if (st_match[c_idx]) begin
                coal_hit = 1'b1;
                coal_idx = c_idx;
            end
        end
    end

    // empty_q implies no valid head, so an ack while empty is ignored.
    assign pop       = !rst && !empty_q && mem_wr_ack;
    assign st_accept = !rst && st_valid && (coal_hit || !full_q || pop);
    assign push      = st_accept && !coal_hit;

    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        // Pop before push: when full, tail == head and the push must win.
        if (pop) begin
            ent_d[head_q].valid = 1'b0;
            head_d              = head_q + PTR_W'(1);
        end
        if (st_accept && coal_hit) begin
            for (int b = 0; b < BE_W; b++) begin
                if (st_be[b]) ent_d[coal_idx].data[8*b +: 8] = st_data[8*b +: 8];
            end
            ent_d[coal_idx].be = ent_d[coal_idx].be | st_be;
        end
        if (push) begin
            ent_d[tail_q].valid = 1'b1;
            ent_d[tail_q].addr  = st_word;
            ent_d[tail_q].data  = st_data;
            ent_d[tail_q].be    = st_be;
            tail_d              = tail_q + PTR_W'(1);
        end
        cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign count       = cnt_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign mem_wr_en   = !empty_q;
    assign mem_wr_addr = mem_wr_en ? ent_q[head_q].addr : '0;
    assign mem_wr_data = mem_wr_en ? ent_q[head_q].data : '0;
    assign mem_wr_be   = mem_wr_en ? ent_q[head_q].be   : '0;

    // Forwarding sees registered state only, so a store accepted this cycle
    // is invisible until next cycle. Oldest-to-youngest walk: younger bytes
    // overwrite older ones.
    always_comb begin
        covered  = '0;
        fwd_data = '0;
        f_idx    = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            f_idx = head_q + PTR_W'(k);
            if (ld_match[f_idx]) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (ent_q[f_idx].be[b]) begin
                        covered[b]          = 1'b1;
                        fwd_data[8*b +: 8]  = ent_q[f_idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign ld_hit      = ld_lookup && ((covered & ld_be) == ld_be) && (ld_be != '0);
    assign ld_conflict = ld_lookup && ((covered & ld_be) != '0) && !ld_hit;
    assign ld_data     = ld_lookup ? fwd_data : '0;
endmodule

// File: tb/tb_store_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_write_buffer
//   Directed bench for store_write_buffer (DEPTH=4, 32-bit address/data).
//   Expected memory writes are queued as stores are driven and checked by a
//   monitor on every write handshake; status and forwarding outputs are
//   checked inline. Inputs change 1 time unit after the rising edge and
//   outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_store_write_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [3:0]  st_be = '0;
    logic        st_accept;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic        mem_wr_ack = 1'b0;
    logic        ld_lookup = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [3:0]  ld_be = '0;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_conflict;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;
    wr_t sb[$];

    always #5 clk = ~clk;

    store_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .st_accept(st_accept),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_be(mem_wr_be), .mem_wr_ack(mem_wr_ack),
        .ld_lookup(ld_lookup), .ld_addr(ld_addr), .ld_be(ld_be),
        .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
        .count(count), .empty(empty), .full(full)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.be   = be;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One-cycle store offer; checks st_accept against the expectation.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic exp_acc, input string tag);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = be;
        @(negedge clk);
        chk(tag, st_accept, exp_acc);
        next_cycle();
        st_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] be, input logic e_hit,
                        input logic e_conf, input logic [31:0] e_data, input string tag);
        ld_lookup = 1'b1;
        ld_addr   = a;
        ld_be     = be;
        @(negedge clk);
        chk({tag, "_hit"}, ld_hit, e_hit);
        chk({tag, "_conflict"}, ld_conflict, e_conf);
        chk({tag, "_data"}, ld_data, e_data);
        next_cycle();
        ld_lookup = 1'b0;
    endtask

    // Ack until empty, bounded; the monitor checks each write.
    task automatic drain(input string tag);
        mem_wr_ack = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (empty) break;
            next_cycle();
        end
        chk(tag, empty, 1'b1);
        mem_wr_ack = 1'b0;
        next_cycle();
    endtask

    // Scoreboard: every write handshake must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && mem_wr_en && mem_wr_ack) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", mem_wr_en, 1'b0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", mem_wr_addr, e.addr);
                chk("wr_data", mem_wr_data, e.data);
                chk("wr_be", mem_wr_be, e.be);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        next_cycle();
        next_cycle();
        rst       = 1'b0;
        ld_lookup = 1'b1;
        ld_addr   = 32'h0;
        ld_be     = 4'hF;
        @(negedge clk);
        chk("rst_count", count, 3'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_accept", st_accept, 1'b0);
        chk("rst_wr_en", mem_wr_en, 1'b0);
        chk("rst_wr_addr", mem_wr_addr, 32'h0);
        chk("rst_wr_data", mem_wr_data, 32'h0);
        chk("rst_wr_be", mem_wr_be, 4'h0);
        chk("rst_ld_hit", ld_hit, 1'b0);
        chk("rst_ld_conflict", ld_conflict, 1'b0);
        chk("rst_ld_data", ld_data, 32'h0);
        next_cycle();
        ld_lookup = 1'b0;

        // Single store, 1-cycle latency to memory, ack in cycle 3.
        exp_wr(32'h100, 32'hDEADBEEF, 4'hF);
        store(32'h100, 32'hDEADBEEF, 4'hF, 1'b1, "t1_accept");
        @(negedge clk);
        chk("t1_wr_en", mem_wr_en, 1'b1);
        chk("t1_wr_addr", mem_wr_addr, 32'h100);
        chk("t1_count1", count, 3'd1);
        next_cycle();
        @(negedge clk);
        chk("t1_hold_data", mem_wr_data, 32'hDEADBEEF);
        next_cycle();
        mem_wr_ack = 1'b1;
        next_cycle();
        mem_wr_ack = 1'b0;
        @(negedge clk);
        chk("t1_empty", empty, 1'b1);
        chk("t1_count0", count, 3'd0);
        next_cycle();

        // Fill to DEPTH, then a held 5th store accepted alongside an ack.
        for (int i = 0; i < 4; i++) begin
            exp_wr(32'h10 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF);
            store(32'h10 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF, 1'b1, "t2_fill_accept");
        end
        st_valid = 1'b1;
        st_addr  = 32'h20;
        st_data  = 32'h5555;
        st_be    = 4'hF;
        @(negedge clk);
        chk("t2_full_reject", st_accept, 1'b0);
        chk("t2_full", full, 1'b1);
        chk("t2_count4", count, 3'd4);
        next_cycle();
        mem_wr_ack = 1'b1;
        @(negedge clk);
        chk("t2_accept_w_ack", st_accept, 1'b1);
        exp_wr(32'h20, 32'h5555, 4'hF);
        next_cycle();
        st_valid   = 1'b0;
        mem_wr_ack = 1'b0;
        @(negedge clk);
        chk("t2_count_kept", count, 3'd4);
        chk("t2_full_kept", full, 1'b1);
        chk("t2_head_adv", mem_wr_addr, 32'h14);
        next_cycle();
        drain("t2_drain");

        // Coalesce into non-head entry B; byte-offset address maps to the word.
        exp_wr(32'h200, 32'hAAAAAAAA, 4'hF);
        exp_wr(32'h300, 32'h22221111, 4'hF);
        store(32'h200, 32'hAAAAAAAA, 4'hF, 1'b1, "t3_a");
        store(32'h300, 32'h00001111, 4'h3, 1'b1, "t3_b");
        store(32'h302, 32'h22220000, 4'hC, 1'b1, "t3_coal");
        @(negedge clk);
        chk("t3_count", count, 3'd2);
        next_cycle();
        drain("t3_drain");

        // Head is never coalesced; a later store merges into the youngest entry.
        exp_wr(32'h200, 32'h11111111, 4'hF);
        exp_wr(32'h200, 32'h22222233, 4'hF);
        store(32'h200, 32'h11111111, 4'hF, 1'b1, "t4_first");
        store(32'h200, 32'h22222222, 4'hF, 1'b1, "t4_second");
        @(negedge clk);
        chk("t4_count2", count, 3'd2);
        next_cycle();
        store(32'h201, 32'h00000033, 4'h1, 1'b1, "t4_third");
        @(negedge clk);
        chk("t4_count_coal", count, 3'd2);
        next_cycle();
        drain("t4_drain");

        // Forwarding.
        exp_wr(32'h400, 32'h000000AB, 4'h1);
        store(32'h400, 32'h000000AB, 4'h1, 1'b1, "t5_st");
        load(32'h400, 4'h1, 1'b1, 1'b0, 32'h000000AB, "t5_full");
        load(32'h400, 4'h3, 1'b0, 1'b1, 32'h000000AB, "t5_partial");
        load(32'h404, 4'hF, 1'b0, 1'b0, 32'h0, "t5_miss");
        // Same-cycle store is not visible to the lookup.
        exp_wr(32'h400, 32'h000000CD, 4'h1);
        ld_lookup = 1'b1;
        ld_addr   = 32'h400;
        ld_be     = 4'h1;
        st_valid  = 1'b1;
        st_addr   = 32'h400;
        st_data   = 32'h000000CD;
        st_be     = 4'h1;
        @(negedge clk);
        chk("t5_same_cycle", ld_data, 32'h000000AB);
        next_cycle();
        st_valid = 1'b0;
        // Youngest entry wins per byte.
        @(negedge clk);
        chk("t5_youngest", ld_data, 32'h000000CD);
        chk("t5_youngest_hit", ld_hit, 1'b1);
        next_cycle();
        ld_lookup = 1'b0;
        drain("t5_drain");

        // Reset mid-drain discards everything.
        store(32'h600, 32'h6, 4'hF, 1'b1, "t6_a");
        store(32'h604, 32'h7, 4'hF, 1'b1, "t6_b");
        store(32'h608, 32'h8, 4'hF, 1'b1, "t6_c");
        @(negedge clk);
        chk("t6_pre_en", mem_wr_en, 1'b1);
        chk("t6_pre_count", count, 3'd3);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_count", count, 3'd0);
        chk("t6_empty", empty, 1'b1);
        chk("t6_wr_en", mem_wr_en, 1'b0);
        chk("t6_wr_addr", mem_wr_addr, 32'h0);
        next_cycle();
        mem_wr_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_no_write", mem_wr_en, 1'b0);
            next_cycle();
        end
        mem_wr_ack = 1'b0;

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
